// File: rtl/mod16_down_timer_pkg.sv
// Shared definitions for the mod16_down_timer block: FSM state encoding and
// the width of the saturating expiry counter.
package mod16_down_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } timer_state_t;

  localparam int EXP_CNT_W = 8;

endpackage

// File: rtl/mod16_down_timer_if.sv
// Connection bundle for mod16_down_timer. clk and rst come in as interface
// ports; everything else is a plain signal the bench/system drives or reads.
//   clk, rst              : clock and synchronous active-high reset
//   en, abort             : count enable, cancel
//   ld_valid/ld_data      : load request and start value
//   ld_ready              : load acceptance
//   cnt, busy, tc, exp_cnt: count value, RUN/HOLD flag, terminal pulse, expiries
interface mod16_down_timer_if
  import mod16_down_timer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic clk,
  input logic rst
);
  logic                 en;
  logic                 abort;
  logic                 ld_valid;
  logic [WIDTH-1:0]     ld_data;
  logic                 ld_ready;
  logic [WIDTH-1:0]     cnt;
  logic                 busy;
  logic                 tc;
  logic [EXP_CNT_W-1:0] exp_cnt;
endinterface

// File: rtl/mod16_down_timer_sat_counter.sv
// Saturating up-counter: increments by one per cycle with inc high and
// sticks at all-ones.
//   clk, rst : clock, synchronous active-high reset (clears to 0)
//   inc      : increment request
//   count    : current value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/mod16_down_timer.sv
// Loadable down-counter with pause, abort and optional auto-reload.
//   clk, rst           : clock, synchronous active-high reset
//   en                 : count enable (low in RUN parks the FSM in HOLD)
//   abort              : cancel an active count (blocks loads when idle)
//   ld_valid, ld_data  : load request / start value
//   ld_ready           : load acceptance (combinational)
//   cnt                : current count
//   busy               : high in RUN or HOLD
//   tc                 : registered terminal-count pulse (cycle cnt first reads 0)
//   exp_cnt            : saturating count of tc pulses
module mod16_down_timer
  import mod16_down_timer_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 abort,
  input  logic                 ld_valid,
  input  logic [WIDTH-1:0]     ld_data,
  output logic                 ld_ready,
  output logic [WIDTH-1:0]     cnt,
  output logic                 busy,
  output logic                 tc,
  output logic [EXP_CNT_W-1:0] exp_cnt
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  timer_state_t     state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             active, ld_fire;

  assign active   = (state_q == ST_RUN) || (state_q == ST_HOLD);
  // The rst term keeps ld_ready defined (high) while reset is held, even
  // before the state register has been cleared.
  assign ld_ready = (rst || state_q == ST_IDLE || state_q == ST_DONE) && !abort;
  assign ld_fire  = ld_valid && ld_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (abort && active) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (ld_fire) begin
      cnt_d    = ld_data;
      reload_d = ld_data;
      if (ld_data == '0) begin
        state_d = ST_DONE;
        tc_d    = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else if (active) begin
      if (!en) begin
        state_d = ST_HOLD;
      end else begin
        // HOLD with en high resumes and decrements on the same edge.
        state_d = ST_RUN;
        if (cnt_q == ONE) begin
          cnt_d = '0;
          tc_d  = 1'b1;
          if (!AUTO_RELOAD) state_d = ST_DONE;
        end else if (cnt_q == '0) begin
          // Only reachable with auto-reload: the cycle after expiry.
          cnt_d = reload_q;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  // Counting tc_d keeps exp_cnt in step with the tc pulse it counts.
  sat_counter #(.W(EXP_CNT_W)) u_exp_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (tc_d),
    .count (exp_cnt)
  );

  assign cnt  = cnt_q;
  assign busy = active;
  assign tc   = tc_q;
endmodule

// File: tb/tb_mod16_down_timer.sv
module tb_mod16_down_timer;
  import mod16_down_timer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mod16_down_timer_if #(.WIDTH(4)) if0 (.clk(clk), .rst(rst));
  mod16_down_timer_if #(.WIDTH(4)) if1 (.clk(clk), .rst(rst));

  mod16_down_timer #(.WIDTH(4), .AUTO_RELOAD(1'b0)) dut0 (
    .clk(if0.clk), .rst(if0.rst), .en(if0.en), .abort(if0.abort),
    .ld_valid(if0.ld_valid), .ld_data(if0.ld_data), .ld_ready(if0.ld_ready),
    .cnt(if0.cnt), .busy(if0.busy), .tc(if0.tc), .exp_cnt(if0.exp_cnt));

  mod16_down_timer #(.WIDTH(4), .AUTO_RELOAD(1'b1)) dut1 (
    .clk(if1.clk), .rst(if1.rst), .en(if1.en), .abort(if1.abort),
    .ld_valid(if1.ld_valid), .ld_data(if1.ld_data), .ld_ready(if1.ld_ready),
    .cnt(if1.cnt), .busy(if1.busy), .tc(if1.tc), .exp_cnt(if1.exp_cnt));

  int vectors = 0;
  int miscompares = 0;
  logic [13:0] sb[$];  // {cnt, tc, busy, exp_cnt}

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] xp);
    vectors++;
    assert (obs === xp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, xp);
    end
  endtask

  task automatic drive(input int d, input logic e, ab, lv, input logic [3:0] ld);
    if (d == 0) begin
      if0.en = e; if0.abort = ab; if0.ld_valid = lv; if0.ld_data = ld;
    end else begin
      if1.en = e; if1.abort = ab; if1.ld_valid = lv; if1.ld_data = ld;
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input int d, input logic e, ab, lv, input logic [3:0] ld,
                      input logic [3:0] xc, input logic xt, xb,
                      input logic [7:0] xe, input string tag);
    logic [13:0] xp, obs;
    drive(d, e, ab, lv, ld);
    sb.push_back({xc, xt, xb, xe});
    @(posedge clk);
    #1;
    xp  = sb.pop_front();
    obs = (d == 0) ? {if0.cnt, if0.tc, if0.busy, if0.exp_cnt}
                   : {if1.cnt, if1.tc, if1.busy, if1.exp_cnt};
    chk(tag, {2'b00, obs}, {2'b00, xp});
  endtask

  initial begin
    int ek, pe;
    rst = 1'b1;
    drive(0, 0, 0, 0, 4'd0);
    drive(1, 0, 0, 0, 4'd0);
    #1;
    chk("rdy_in_reset", {15'd0, if0.ld_ready}, 16'd1);
    if0.abort = 1'b1;
    #1;
    chk("rdy_reset_abort", {15'd0, if0.ld_ready}, 16'd0);
    if0.abort = 1'b0;
    repeat (5) step(0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 8'd0, "reset");
    rst = 1'b0;

    // basic countdown from 5
    step(0, 1, 0, 1, 4'd5, 4'd5, 0, 1, 8'd0, "load5");
    for (int v = 4; v >= 1; v--) step(0, 1, 0, 0, 4'd0, 4'(v), 0, 1, 8'd0, "cd5");
    step(0, 1, 0, 0, 4'd0, 4'd0, 1, 0, 8'd1, "cd5_tc");
    chk("state_done", 16'(dut0.state_q), 16'(ST_DONE));
    step(0, 1, 0, 0, 4'd0, 4'd0, 0, 0, 8'd1, "done_hold");

    // pause at 6 for three cycles
    step(0, 1, 0, 1, 4'd9, 4'd9, 0, 1, 8'd1, "load9");
    for (int v = 8; v >= 6; v--) step(0, 1, 0, 0, 4'd0, 4'(v), 0, 1, 8'd1, "cd9");
    repeat (3) step(0, 0, 0, 0, 4'd0, 4'd6, 0, 1, 8'd1, "hold6");
    chk("state_hold", 16'(dut0.state_q), 16'(ST_HOLD));
    step(0, 1, 0, 0, 4'd0, 4'd5, 0, 1, 8'd1, "resume");
    for (int v = 4; v >= 1; v--) step(0, 1, 0, 0, 4'd0, 4'(v), 0, 1, 8'd1, "cd9b");
    step(0, 1, 0, 0, 4'd0, 4'd0, 1, 0, 8'd2, "cd9_tc");

    // load ignored while busy, then abort at 4
    step(0, 1, 0, 1, 4'd7, 4'd7, 0, 1, 8'd2, "load7");
    step(0, 1, 0, 1, 4'd12, 4'd6, 0, 1, 8'd2, "ld_while_busy");
    step(0, 1, 0, 0, 4'd0, 4'd5, 0, 1, 8'd2, "cd7");
    step(0, 1, 0, 0, 4'd0, 4'd4, 0, 1, 8'd2, "cd7");
    step(0, 1, 1, 0, 4'd0, 4'd0, 0, 0, 8'd2, "abort");
    chk("state_idle", 16'(dut0.state_q), 16'(ST_IDLE));
    step(0, 1, 0, 0, 4'd0, 4'd0, 0, 0, 8'd2, "post_abort");

    // abort with ld_valid in IDLE: no load
    drive(0, 1, 1, 1, 4'd5);
    #1;
    chk("rdy_abort_idle", {15'd0, if0.ld_ready}, 16'd0);
    step(0, 1, 1, 1, 4'd5, 4'd0, 0, 0, 8'd2, "abort_blocks_ld");

    // load 0 -> DONE with tc
    step(0, 1, 0, 1, 4'd0, 4'd0, 1, 0, 8'd3, "load0");
    step(0, 1, 0, 0, 4'd0, 4'd0, 0, 0, 8'd3, "load0_after");

    // load 15 -> 16 edges to tc, no wrap afterwards
    step(0, 1, 0, 1, 4'd15, 4'd15, 0, 1, 8'd3, "load15");
    for (int v = 14; v >= 1; v--) step(0, 1, 0, 0, 4'd0, 4'(v), 0, 1, 8'd3, "cd15");
    step(0, 1, 0, 0, 4'd0, 4'd0, 1, 0, 8'd4, "cd15_tc");
    step(0, 1, 0, 0, 4'd0, 4'd0, 0, 0, 8'd4, "no_wrap");

    // reset mid-count at 7
    step(0, 1, 0, 1, 4'd10, 4'd10, 0, 1, 8'd4, "load10");
    for (int v = 9; v >= 7; v--) step(0, 1, 0, 0, 4'd0, 4'(v), 0, 1, 8'd4, "cd10");
    rst = 1'b1;
    step(0, 1, 1, 1, 4'd3, 4'd0, 0, 0, 8'd0, "rst_mid");
    rst = 1'b0;
    drive(0, 0, 0, 0, 4'd0);

    // auto-reload: period 4, exp_cnt saturates at 255
    step(1, 1, 0, 1, 4'd3, 4'd3, 0, 1, 8'd0, "ar_load3");
    for (int k = 1; k <= 300; k++) begin
      pe = (k - 1 > 255) ? 255 : k - 1;
      ek = (k > 255) ? 255 : k;
      step(1, 1, 0, 0, 4'd0, 4'd2, 0, 1, 8'(pe), "ar_2");
      step(1, 1, 0, 0, 4'd0, 4'd1, 0, 1, 8'(pe), "ar_1");
      step(1, 1, 0, 0, 4'd0, 4'd0, 1, 1, 8'(ek), "ar_tc");
      step(1, 1, 0, 0, 4'd0, 4'd3, 0, 1, 8'(ek), "ar_reload");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mod16_down_timer.md
MOD16_DOWN_TIMER -- requirements
Module: mod16_down_timer

Interface
REQ-001 Parameter WIDTH, default 4, counter width (mod 2^WIDTH).
REQ-002 Parameter AUTO_RELOAD, default 0; when 1, the counter reloads on expiry instead of stopping.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 en  in  1  count enable; low pauses the count in RUN.
REQ-006 abort  in  1  cancels an active count.
REQ-007 ld_valid  in  1  load request.
REQ-008 ld_data  in  WIDTH  start value.
REQ-009 ld_ready  out  1  load acceptance.
REQ-010 cnt  out  WIDTH  current count value.
REQ-011 busy  out  1  high while in RUN or HOLD.
REQ-012 tc  out  1  terminal-count pulse.
REQ-013 exp_cnt  out  8  saturating count of expiries.

Function
REQ-014 FSM states SHALL be IDLE, RUN, HOLD and DONE.
REQ-015 ld_ready SHALL be combinational, equal to (state==IDLE or state==DONE) and !abort.
REQ-016 A load SHALL be accepted on the edge where ld_valid and ld_ready are both high; cnt <= ld_data and reload_q <= ld_data.
REQ-017 An accepted load with ld_data!=0 SHALL enter RUN; with ld_data==0 it SHALL enter DONE with tc=1 for that cycle.
REQ-018 In RUN with en=1, cnt SHALL decrement by 1 per cycle.
REQ-019 In RUN with en=0, the FSM SHALL go to HOLD with cnt held; in HOLD with en=1, it SHALL return to RUN and resume decrementing on that edge.
REQ-020 When cnt decrements from 1 to 0, tc SHALL be registered high for exactly the one cycle in which cnt first reads 0.
REQ-021 On expiry with AUTO_RELOAD=0, the FSM SHALL go to DONE and cnt SHALL stay 0.
REQ-022 On expiry with AUTO_RELOAD=1, the next edge SHALL load cnt <= reload_q and the FSM SHALL remain RUN.
  - Period SHALL be reload_q+1 cycles with en held high.
REQ-023 Each tc pulse SHALL increment exp_cnt; exp_cnt SHALL saturate at 255.
REQ-024 abort in RUN or HOLD SHALL force IDLE and cnt=0 on the next edge, with no tc pulse; abort in IDLE or DONE SHALL be a no-op that blocks loads.
REQ-025 Priority SHALL be rst > abort > load > count.
REQ-026 No wrap-around below 0: cnt SHALL never transition 0 -> 2^WIDTH-1.
REQ-027 ld_valid while busy SHALL be ignored; no load is queued.

Reset
REQ-028 On rst, the outputs SHALL be: state IDLE, cnt=0, reload_q=0, tc=0, exp_cnt=0, busy=0.
REQ-029 Reset asserted mid-count SHALL take effect on the next edge regardless of en, abort or ld_valid.
REQ-030 ld_ready SHALL read 1 during reset unless abort is high.

Structure
REQ-031 A shared package SHALL hold the state enum typedef (timer_state_t) and the EXP_CNT_W=8 constant.
REQ-032 The saturating expiry counter SHALL be a sub-module, sat_counter, instantiated once.
REQ-033 The block SHALL connect through an interface carrying clk and rst as interface ports, matching the existing counter bench style.

Verification
REQ-034 Basic countdown: rst 5 cycles, load 5 with en=1 -> cnt 5,4,3,2,1,0; tc high only in the cnt==0 cycle; DONE; exp_cnt=1.
REQ-035 Pause: load 9, drop en at cnt=6 for 3 cycles -> cnt holds 6, busy=1, state HOLD; resume -> 5 on the first en-high edge.
REQ-036 Auto-reload (AUTO_RELOAD=1): load 3 -> tc period 4 cycles; after 300 expiries exp_cnt=255.
REQ-037 Abort and priority: abort at cnt=4 -> IDLE, cnt=0, no tc. Abort and ld_valid in the same cycle in IDLE -> ld_ready=0, no load.
REQ-038 Boundary loads: load 0 -> DONE, tc one cycle. Load 15 -> 16 cycles to tc, no wrap. ld_valid while busy -> cnt unaffected.
REQ-039 Reset mid-count: rst at cnt=7 -> cnt=0, tc=0, exp_cnt=0 next cycle.
